iter_shifter: RTL and testbench
===============================

# iter_shifter

Sequential 16-bit shifter for the execute stage: accepts a value, a 3-bit shift op and a 4-bit shift amount, then applies one 1-bit shift per clock until the amount is exhausted. It sits directly upstream of the existing 1-bit shift cell `shifter_1`, which it instantiates and feeds every cycle. It replaces a full barrel shifter where area matters more than latency. Both sides use valid/ready handshakes.

## Interface
- No parameters; data width fixed at 16, shift amount at 4 bits.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  block can accept a request; high exactly in IDLE.
- `in_data`  in  16  operand.
- `in_op`  in  3  000 ROL, 001 ROR, 010 SLL, 011 SRA, 100 SRL; 101–111 illegal.
- `in_shamt`  in  4  shift amount, 0–15.
- `kill`  in  1  synchronous abort; returns to IDLE, result discarded.
- `out_valid`  out  1  result available; high exactly in DONE.
- `out_ready`  in  1  consumer takes result.
- `out_data`  out  16  result register.
- `out_err`  out  1  valid only with `out_valid`; set when the accepted op was illegal.

## Operation
- States: IDLE, SHIFT, DONE. Registers: `data[15:0]`, `op[2:0]`, `cnt[3:0]`, `err`.
- IDLE: on `in_valid` with no `kill`, latch `in_data`, `in_op` and `in_shamt` into `data`, `op` and `cnt`.
  - `err` = (op > 100).
  - If `in_shamt`==0 or op is illegal, go to DONE. Otherwise go to SHIFT.
- SHIFT: each cycle `data` <= `shifter_1(data, op, sh=1)` and `cnt` <= `cnt`-1. Leave for DONE on the cycle where `cnt`==1.
- Shift semantics per 1-bit step:
  - ROL: {d[14:0], d[15]}
  - ROR: {d[0], d[15:1]}
  - SLL: {d[14:0], 0}
  - SRA: {d[15], d[15:1]}
  - SRL: {0, d[15:1]}
- DONE: `out_data`=`data`, `out_valid`=1, `out_err`=`err`. On `out_ready`, go to IDLE. Hold all outputs stable until then.
- Illegal op: `data` is returned unmodified and `out_err`=1. No shifting occurs.
- `kill` has highest priority in every state. The next state is IDLE and `data`/`cnt`/`err` are untouched (don't-care). `kill` and `in_valid` together in IDLE means no accept.
- `in_*` are sampled only at the accept edge; changes during SHIFT/DONE are ignored.

## Timing
- Reset values: state=IDLE, `data`=16'h0000, `op`=000, `cnt`=0, `err`=0.
  - Therefore `in_ready`=1, `out_valid`=0, `out_data`=16'h0000 and `out_err`=0 while `rst` is high and after release.
- Accept at edge k: `out_valid` rises after edge k+`shamt`, or after edge k for an illegal op. `shamt`=0 gives one cycle from request to result.
- DONE to IDLE happens at the edge where `out_ready`=1. The earliest next accept is the following edge, so minimum initiation interval is `shamt`+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational input-to-output path.
- `rst` asserted mid-SHIFT or in DONE forces the reset values immediately (asynchronously); any in-flight result is lost.

## Structure
- Shared package/include:
  - op encodings `OP_ROL`=3'b000, `OP_ROR`=3'b001, `OP_SLL`=3'b010, `OP_SRA`=3'b011, `OP_SRL`=3'b100
  - state encodings `ST_IDLE`, `ST_SHIFT`, `ST_DONE` (2-bit)
  - width constants `DW`=16 and `SW`=4
- One sub-module: `shifter_1`, instantiated once, input `data`, op `op`, `sh` tied to 1. Its output feeds the `data` register in SHIFT.
- Remaining logic is a state register, a down-counter and next-state/output decode.

## Test plan
- Reset mid-operation: ROL, 16'h8001, shamt 1 -> `out_data`=16'h0003 after 1 shift cycle. Repeat with `rst` asserted during SHIFT -> outputs return to reset values in the same cycle; `in_ready`=1 after release.
- SRA, 16'h8000, shamt 15 -> 16'hFFFF with `out_valid` 15 cycles after accept. Then SRL, 16'h8000, shamt 15 -> 16'h0001.
- SLL, 16'h00FF, shamt 4 -> 16'h0FF0. ROR, 16'h0001, shamt 4 -> 16'h1000. Hold `out_ready`=0 for 5 cycles -> `out_data` and `out_valid` stable; `in_ready`=0 throughout.
- shamt 0, op SRL, 16'hA5A5 -> 16'hA5A5 on the cycle after accept, `out_err`=0. Op 3'b110, 16'h1234, shamt 7 -> 16'h1234 with `out_err`=1 on the cycle after accept.
- `kill` during SHIFT (SLL, shamt 10, after 3 cycles) -> IDLE next cycle, `out_valid` never rises. `kill` together with `in_valid` in IDLE -> no accept.
- Back-to-back requests with `out_ready` tied high -> each accepted exactly `shamt`+2 cycles apart, with all results correct.

Source files
------------

// File: rtl/iter_shifter_pkg.sv
// iter_shifter shared types and constants.
// Op and state encodings, datapath widths.
package iter_shifter_pkg;

  localparam int DW = 16;
  localparam int SW = 4;

  localparam logic [2:0] OP_ROL = 3'b000;
  localparam logic [2:0] OP_ROR = 3'b001;
  localparam logic [2:0] OP_SLL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_SRL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/iter_shifter_shifter_1.sv
// shifter_1: single-step 1-bit shift cell.
// Passes data through when sh is low or op is illegal.
module shifter_1
  import iter_shifter_pkg::*;
(
  input  logic [DW-1:0] data,
  input  logic [2:0]    op,
  input  logic          sh,
  output logic [DW-1:0] res
);

  always_comb begin
    res = data;
    if (sh) begin
      unique case (1'b1)
        (op == OP_ROL): res = {data[DW-2:0], data[DW-1]};
        (op == OP_ROR): res = {data[0], data[DW-1:1]};
        (op == OP_SLL): res = {data[DW-2:0], 1'b0};
        (op == OP_SRA): res = {data[DW-1], data[DW-1:1]};
        (op == OP_SRL): res = {1'b0, data[DW-1:1]};
        default:        res = data;
      endcase
    end
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: iterative 16-bit shifter, one bit per clock.
// valid/ready on both sides, kill aborts to IDLE.
module iter_shifter
  import iter_shifter_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_op,
  input  logic [SW-1:0] in_shamt,
  input  logic          kill,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_err
);

  state_t        state, nxt;
  logic [DW-1:0] data;
  logic [DW-1:0] shf;
  logic [2:0]    op;
  logic [SW-1:0] cnt;
  logic          err;
  logic          bad_op;

  assign bad_op = (in_op > OP_SRL);

  shifter_1 u_sh (
    .data (data),
    .op   (op),
    .sh   (1'b1),
    .res  (shf)
  );

  always_comb begin
    nxt = state;
    if (kill) begin
      nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (in_valid)
            nxt = (in_shamt == '0 || bad_op)
                  ? ST_DONE : ST_SHIFT;
        end
        ST_SHIFT: begin
          if (cnt == 4'd1) nxt = ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) nxt = ST_IDLE;
        end
        default: nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      data  <= '0;
      op    <= OP_ROL;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      if (!kill && state == ST_IDLE && in_valid) begin
        data <= in_data;
        op   <= in_op;
        cnt  <= in_shamt;
        err  <= bad_op;
      end else if (!kill && state == ST_SHIFT) begin
        data <= shf;
        cnt  <= cnt - 4'd1;
      end
    end
  end

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign out_data  = data;
  assign out_err   = err;

endmodule

// File: tb/tb_iter_shifter.sv
// tb_iter_shifter: directed checks of iter_shifter.
// Expected values are hand-computed constants.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [2:0]  in_op;
  logic [3:0]  in_shamt;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  int nchk = 0;
  int npass = 0;
  int cyc = 0;

  iter_shifter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .in_shamt  (in_shamt),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, then measure latency to out_valid.
  task automatic run(input string tag,
                     input logic [2:0] op,
                     input logic [15:0] d,
                     input logic [3:0] s,
                     input logic [15:0] exp,
                     input logic experr,
                     input int explat);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_rdy"}, in_ready, 1'b1);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = s;
    step();
    in_valid = 1'b0;
    in_data  = 16'hDEAD;
    in_op    = 3'b000;
    in_shamt = 4'd9;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, n, explat);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_err"}, out_err, experr);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    int t0;
    int t1;
    int ps;
    logic [2:0]  bop [4];
    logic [15:0] bd  [4];
    logic [3:0]  bs  [4];
    logic [15:0] be  [4];

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_op = '0;
    in_shamt = '0;
    kill = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst_rdy", in_ready, 1'b1);
    chk("rst_vld", out_valid, 1'b0);
    chk("rst_data", out_data, 16'h0000);
    chk("rst_err", out_err, 1'b0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("post_rst_rdy", in_ready, 1'b1);
    chk("post_rst_vld", out_valid, 1'b0);

    run("rol1", 3'b000, 16'h8001, 4'd1, 16'h0003, 1'b0, 1);
    drain();

    // Async reset while shifting.
    in_valid = 1'b1;
    in_op = 3'b000;
    in_data = 16'h8001;
    in_shamt = 4'd5;
    step();
    in_valid = 1'b0;
    step();
    chk("mid_rdy0", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_rdy", in_ready, 1'b1);
    chk("arst_vld", out_valid, 1'b0);
    chk("arst_data", out_data, 16'h0000);
    chk("arst_err", out_err, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk("arst_rel_rdy", in_ready, 1'b1);

    run("sra15", 3'b011, 16'h8000, 4'd15, 16'hFFFF, 1'b0, 15);
    drain();
    run("srl15", 3'b100, 16'h8000, 4'd15, 16'h0001, 1'b0, 15);
    drain();
    run("sll4", 3'b010, 16'h00FF, 4'd4, 16'h0FF0, 1'b0, 4);
    drain();
    run("ror4", 3'b001, 16'h0001, 4'd4, 16'h1000, 1'b0, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_vld", out_valid, 1'b1);
      chk("hold_data", out_data, 16'h1000);
      chk("hold_rdy", in_ready, 1'b0);
    end
    drain();
    chk("ror4_idle", in_ready, 1'b1);

    run("srl0", 3'b100, 16'hA5A5, 4'd0, 16'hA5A5, 1'b0, 0);
    drain();
    run("ill", 3'b110, 16'h1234, 4'd7, 16'h1234, 1'b1, 0);
    drain();

    // Kill during SHIFT.
    in_valid = 1'b1;
    in_op = 3'b010;
    in_data = 16'h0001;
    in_shamt = 4'd10;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_rdy", in_ready, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      step();
    end
    chk("kill_novld", seen, 1'b0);

    // Kill with in_valid in IDLE.
    in_valid = 1'b1;
    kill = 1'b1;
    in_op = 3'b010;
    in_data = 16'h0003;
    in_shamt = 4'd3;
    step();
    in_valid = 1'b0;
    kill = 1'b0;
    chk("kv_rdy", in_ready, 1'b1);
    chk("kv_vld", out_valid, 1'b0);
    step();
    step();
    step();
    step();
    chk("kv_vld2", out_valid, 1'b0);

    // Back-to-back with out_ready high.
    bop[0] = 3'b000; bd[0] = 16'h1234;
    bs[0] = 4'd4;    be[0] = 16'h2341;
    bop[1] = 3'b100; bd[1] = 16'hF000;
    bs[1] = 4'd3;    be[1] = 16'h1E00;
    bop[2] = 3'b011; bd[2] = 16'h8421;
    bs[2] = 4'd1;    be[2] = 16'hC210;
    bop[3] = 3'b010; bd[3] = 16'h0001;
    bs[3] = 4'd0;    be[3] = 16'h0001;
    out_ready = 1'b1;
    t0 = 0;
    ps = 0;
    for (int i = 0; i < 4; i++) begin
      int n;
      in_valid = 1'b1;
      in_op = bop[i];
      in_data = bd[i];
      in_shamt = bs[i];
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      t1 = cyc;
      if (i > 0) chk("b2b_gap", t1 - t0, ps + 2);
      t0 = t1;
      ps = int'(bs[i]);
      n = 0;
      while (!out_valid && n < 40) begin
        step();
        n++;
      end
      chk("b2b_data", out_data, be[i]);
      step();
      chk("b2b_rdy", in_ready, 1'b1);
    end
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
